sequenciador_notas: RTL
=======================

// Module: sequenciador_notas
// PURPOSE
//  Melody sequencer that drives the note/octave 7-segment decoder (ModuloDisp).
//  Holds a small programmable melody table; on START it plays entries 0..LEN.
//  Each entry is presented on TOM_OUT/NOTAS_OUT for dur*TICK_DIV cycles,
//  followed by a one-cycle articulation gap. Optional looping and stop.
//  Sits between the user/control logic and the display decoder inputs.
// PARAMETERS
//  AW        4   table address width; DEPTH = 2**AW entries
//  DUR_W     4   duration field width, in units of TICK_DIV cycles
//  TICK_DIV  4   clock cycles per duration unit (>=1)
// PORTS
//  CLK         in   1         system clock, rising edge
//  RST_N       in   1         asynchronous reset, active-low
//  PROG_WE     in   1         table write strobe
//  PROG_ADDR   in   AW        table write address
//  PROG_DATA   in   DUR_W+4   {dur[DUR_W-1:0], tom, nota[2:0]}
//  LEN         in   AW        index of last entry to play; captured on START
//  START       in   1         begin playback (level, sampled in IDLE)
//  STOP        in   1         abort playback
//  LOOP        in   1         replay from entry 0 after entry LEN
//  TOM_OUT     out  1         octave bit to decoder TOM input
//  NOTAS_OUT   out  3         note code to decoder NOTAS input
//  NOTE_VALID  out  1         high while a note is sounding/displayed
//  BUSY        out  1         state != IDLE
//  DONE        out  1         one-cycle pulse at end of non-looped melody
//  IDX         out  AW        index of current entry
// BEHAVIOUR
//  - Reset (async, RST_N=0): state IDLE; TOM_OUT=0, NOTAS_OUT=000,
//    NOTE_VALID=0, BUSY=0, DONE=0, IDX=0; prescaler and unit counter 0.
//    Table contents not reset.
//  - Table: synchronous write on PROG_WE only in IDLE; writes while BUSY dropped.
//  - FSM IDLE->LOAD->PLAY->GAP->{LOAD|IDLE}.
//  - IDLE: START=1 & STOP=0 -> LOAD; capture LEN; IDX=0.
//  - LOAD (1 cycle): read entry[IDX]; next edge loads TOM_OUT/NOTAS_OUT,
//    NOTE_VALID=1, units=dur (dur==0 treated as 1), prescaler=0 -> PLAY.
//  - PLAY: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 units decrements;
//    on last unit tick -> GAP. Note held exactly max(dur,1)*TICK_DIV cycles.
//  - GAP (1 cycle): NOTE_VALID=0, TOM_OUT/NOTAS_OUT hold. Then:
//    IDX<LEN -> IDX+1, LOAD; IDX==LEN & LOOP=1 -> IDX=0, LOAD (LOOP sampled
//    here); IDX==LEN & LOOP=0 -> DONE=1 for one cycle, IDLE.
//  - Latency: START sampled at edge t -> LOAD after t, NOTE_VALID high after
//    t+1. Note period = 1 (LOAD) + max(dur,1)*TICK_DIV + 1 (GAP).
//  - Entering IDLE (end or STOP): TOM_OUT=0, NOTAS_OUT=000, NOTE_VALID=0, IDX=0.
//  - STOP=1 in any non-IDLE state: IDLE at next edge, no DONE pulse.
//    STOP wins over simultaneous START. START while BUSY ignored.
//  - LEN=0 plays single entry. IDX never exceeds captured LEN.
//  - RST_N low mid-note: immediate return to reset values.
// CONFIGURATION
//  SEQ_PAUSE_EN defined: extra input PAUSE (1 bit). PAUSE=1 in PLAY freezes
//    prescaler and unit counter; NOTE_VALID and outputs hold. Ignored in
//    other states; STOP still aborts while paused.
//  Not defined: no PAUSE port; PLAY never stalls.
// TESTING (TICK_DIV=4, DUR_W=4, AW=4)
//  1 RST_N=0 mid-play -> all outputs 0 immediately, BUSY=0.
//  2 Program {2,0,001},{1,1,101},{3,0,111}, LEN=2, START -> NOTAS_OUT 001 valid
//    8 cyc, gap, 101/TOM 1 4 cyc, gap, 111 12 cyc, gap, DONE 1 cyc, BUSY=0.
//  3 Same with LOOP=1 -> after entry 2 gap, IDX=0 and 001 replays; no DONE.
//  4 STOP asserted 3 cycles into entry 1 -> next cycle IDLE, NOTE_VALID=0,
//    IDX=0, NOTAS_OUT=000, DONE stays 0.
//  5 PROG_WE to addr 0 while BUSY -> entry unchanged on replay; dur=0 entry
//    sounds 4 cycles.
//  6 SEQ_PAUSE_EN: PAUSE high 5 cycles during 8-cycle note -> NOTE_VALID high
//    13 cycles; outputs stable throughout.

Source files
------------

// File: rtl/sequenciador_notas.sv
// sequenciador_notas: melody sequencer feeding the note/octave 7-segment
// decoder. A small programmable table of {dur, tom, nota} entries is played
// from index 0 to a captured last index. Each note is held for
// max(dur,1)*TICK_DIV cycles and followed by a one-cycle articulation gap.
// Optional feature macro: SEQ_PAUSE_EN adds a PAUSE input that freezes the
// note timer while a note is sounding.
//
// Handshake: START is a level sampled only in IDLE and ignored while BUSY.
// STOP aborts any non-IDLE state at the next edge and wins over START.
// DONE is a single-cycle pulse, emitted only at the natural end of a
// non-looped melody.
module sequenciador_notas #(
  parameter int AW       = 4,
  parameter int DUR_W    = 4,
  parameter int TICK_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PROG_WE,
  input  logic [AW-1:0]    PROG_ADDR,
  input  logic [DUR_W+3:0] PROG_DATA,
  input  logic [AW-1:0]    LEN,
  input  logic             START,
  input  logic             STOP,
  input  logic             LOOP,
`ifdef SEQ_PAUSE_EN
  input  logic             PAUSE,
`endif
  output logic             TOM_OUT,
  output logic [2:0]       NOTAS_OUT,
  output logic             NOTE_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic [AW-1:0]    IDX,
  output logic [1:0]       STATE_DBG
);

  localparam int DEPTH = 2 ** AW;
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    len_q, len_d;
  logic             tom_q, tom_d;
  logic [2:0]       notas_q, notas_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DUR_W-1:0] units_q, units_d;

  logic [DUR_W+3:0] mem_q [DEPTH];
  logic [DUR_W+3:0] entry;
  logic [DUR_W-1:0] entry_dur;
  logic             pause_w;

`ifdef SEQ_PAUSE_EN
  assign pause_w = PAUSE;
`else
  assign pause_w = 1'b0;
`endif

  assign entry     = mem_q[idx_q];
  assign entry_dur = entry[DUR_W+3:4];

  // Melody table: written only while idle so a playing melody never changes.
  always_ff @(posedge CLK) begin
    if (PROG_WE && (state_q == S_IDLE)) begin
      mem_q[PROG_ADDR] <= PROG_DATA;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      tom_q   <= 1'b0;
      notas_q <= 3'b000;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      units_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tom_q   <= tom_d;
      notas_q <= notas_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      units_q <= units_d;
    end
  end

  // Next-state and datapath update; STOP overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    tom_d   = tom_q;
    notas_d = notas_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    presc_d = presc_q;
    units_d = units_q;

    case (state_q)
      S_IDLE: begin
        if (START && !STOP) begin
          state_d = S_LOAD;
          len_d   = LEN;
          idx_d   = '0;
        end
      end

      S_LOAD: begin
        state_d = S_PLAY;
        tom_d   = entry[3];
        notas_d = entry[2:0];
        valid_d = 1'b1;
        units_d = (entry_dur == '0) ? DUR_W'(1) : entry_dur;
        presc_d = '0;
      end

      S_PLAY: begin
        if (!pause_w) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (units_q == DUR_W'(1)) begin
              state_d = S_GAP;
              valid_d = 1'b0;
            end else begin
              units_d = units_q - DUR_W'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end

      S_GAP: begin
        if (idx_q < len_q) begin
          idx_d   = idx_q + AW'(1);
          state_d = S_LOAD;
        end else if (LOOP) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          idx_d   = '0;
          tom_d   = 1'b0;
          notas_d = 3'b000;
          valid_d = 1'b0;
          presc_d = '0;
          units_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && STOP) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      idx_d   = '0;
      tom_d   = 1'b0;
      notas_d = 3'b000;
      valid_d = 1'b0;
      presc_d = '0;
      units_d = '0;
    end
  end

  assign TOM_OUT    = tom_q;
  assign NOTAS_OUT  = notas_q;
  assign NOTE_VALID = valid_q;
  assign BUSY       = (state_q != S_IDLE);
  assign DONE       = done_q;
  assign IDX        = idx_q;
  assign STATE_DBG  = state_q;

endmodule
